// File: rtl/frame_loader.sv
// ---------------------------------------------------------------------------
// frame_loader
//
// Stream-to-memory loader. Collects a byte stream over a valid/ready
// handshake, packs each group of four bytes big-endian (first byte lands in
// bits [31:24]) into a 32-bit word, and issues one single-cycle write per
// word to the data memory. The core is held in reset until the requested
// number of words has been written.
//
// Parameters:
//   ADDR_WIDTH   width of the word index; up to 2^ADDR_WIDTH words per load
//                (must be below 30 so word offsets fit in 32 bits)
//   BASE_ADDR    word-aligned byte address of the first word written
//
// Ports:
//   Clk           system clock, rising edge
//   Reset         asynchronous active-high reset
//   Start         begin a load (honoured only in IDLE and DONE)
//   WordCount     number of words to load, latched on an accepted Start
//   ByteIn        stream data byte
//   ByteValid     ByteIn carries a valid byte
//   ByteReady     loader accepts a byte this cycle
//   MemAddress    byte address of the current/last write
//   MemWriteData  assembled word of the current/last write
//   MemWrite      single-cycle write strobe
//   CoreHold      holds the core in reset until the load completes
//   Busy          load in progress (COLLECT or WRITE)
//   Done          load complete
// ---------------------------------------------------------------------------
module frame_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [ADDR_WIDTH:0]   WordCount,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic [31:0]           MemAddress,
    output logic [31:0]           MemWriteData,
    output logic                  MemWrite,
    output logic                  CoreHold,
    output logic                  Busy,
    output logic                  Done
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH:0]   word_total;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            byte_cnt;
    // Only the first three bytes of a word need holding; the fourth byte is
    // merged straight into the output word register when it arrives.
    logic [23:0]           word_sr;
    logic [31:0]           addr_q;
    logic [31:0]           data_q;

    // word_idx + 1, one bit wider so a full 2^ADDR_WIDTH load compares
    // correctly against the latched word count.
    logic [ADDR_WIDTH:0]   idx_next;
    logic [31:0]           word_offset;

    assign idx_next    = {1'b0, word_idx} + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign word_offset = {{(30 - ADDR_WIDTH){1'b0}}, word_idx, 2'b00};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            word_total <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            word_sr    <= '0;
            addr_q     <= BASE_ADDR;
            data_q     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        if (WordCount != '0) begin
                            word_total <= WordCount;
                            word_idx   <= '0;
                            byte_cnt   <= '0;
                            state      <= ST_COLLECT;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_COLLECT: begin
                    // ByteReady is high throughout COLLECT, so ByteValid
                    // alone marks a transfer.
                    if (ByteValid) begin
                        word_sr  <= {word_sr[15:0], ByteIn};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Output registers change only here, so they hold
                            // their last values whenever MemWrite is low.
                            data_q <= {word_sr, ByteIn};
                            addr_q <= BASE_ADDR + word_offset;
                            state  <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (idx_next == word_total) begin
                        state <= ST_DONE;
                    end else begin
                        word_idx <= idx_next[ADDR_WIDTH-1:0];
                        byte_cnt <= '0;
                        state    <= ST_COLLECT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ByteReady    = (state == ST_COLLECT);
    assign MemWrite     = (state == ST_WRITE);
    assign MemAddress   = addr_q;
    assign MemWriteData = data_q;
    assign CoreHold     = (state != ST_DONE);
    assign Busy         = (state == ST_COLLECT) || (state == ST_WRITE);
    assign Done         = (state == ST_DONE);

endmodule
